f_fetch_seq: RTL and testbench
==============================

Name: f_fetch_seq

Overview:
- Fetch-stage sequencer for the 5-stage MIPS pipeline. It owns the fetch PC register and picks the next PC from five sources: exception entrance, stall hold, ERET return, D-stage branch/jump target, and sequential PC+4.
- It also flags fetch address errors, marks delay-slot fetches, requests nullification of the instruction fetched behind ERET, and provides a stall watchdog plus an exception-event counter for debug.

Parameters:
- START, 32'h0000_3000, reset/boot PC.
- EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entrance.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFF, highest legal fetch address (inclusive).
- WDOG_MAX, 64, consecutive stall cycles before the watchdog trips.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hazard unit freeze of F/D.
- req  in  1  CP0 exception/interrupt request (M stage).
- eret  in  1  ERET decoded in D.
- epc  in  32  CP0 EPC, valid with eret.
- br_taken  in  1  D-stage branch/jump resolved taken.
- br_target  in  32  D-stage target, valid with br_taken.
- d_is_branch  in  1  instruction currently in D is a branch/jump.
- pc  out  32  current fetch PC (registered).
- f_bd  out  1  instruction in F is a delay slot.
- f_adel  out  1  fetch address error on current pc.
- f_flush  out  1  F/D must load a bubble at the next edge.
- state  out  2  FSM state, for debug.
- stall_timeout  out  1  sticky watchdog flag.
- exc_count  out  16  saturating count of accepted req.

Behaviour:
- Reset (async): pc=START, state=RUN, hold counter=0, stall_timeout=0, exc_count=0. Combinational outputs follow from these values.
- Next-PC priority (combinational npc): req → EXC_ENTRY; else stall → pc; else eret → epc; else br_taken → br_target; else pc+4. The +4 is modulo 2^32. pc<=npc every edge (no separate enable).
- req overrides stall. Under stall, eret and br_taken are ignored; D holds, so they are re-presented.
- If eret and br_taken are both asserted, eret wins. This cannot happen legally, but the behaviour is defined.
- f_flush = eret & ~stall & ~req. The instruction fetched behind ERET is not a delay slot and is discarded. req does not raise f_flush; CP0 flushes the whole pipeline itself.
- f_bd = d_is_branch & (state != EXC). There is no delay-slot attribution on the first handler fetch.
- f_adel = (pc[1:0]!=0) | (pc<IM_LO) | (pc>IM_HI), combinational from registered pc. A misaligned target therefore raises f_adel one cycle after the redirect. pc keeps advancing; CP0 decides.
- FSM states (2 bits): RUN=0, HOLD=1, EXC=2, RET=3. Transitions are evaluated at each edge:
  - req → EXC, from any state.
  - else stall → HOLD.
  - else eret → RET.
  - else → RUN.
- EXC and RET each last exactly one cycle unless re-entered.
- Watchdog:
  - The 7-bit hold counter increments each edge with stall=1 and req=0; it clears on any edge with stall=0 or req=1.
  - When the counter reaches WDOG_MAX, stall_timeout is set.
  - stall_timeout stays set until reset.
  - The counter saturates at WDOG_MAX.
- exc_count increments on each edge with req=1 and saturates at 16'hFFFF. Back-to-back req counts every cycle.
- Reset mid-stall or mid-redirect: all of the above return to reset values immediately, with no pending redirect kept.

Decomposition:
- Shared package/include entries: `instr_start`, `exception_entrance`, IM bounds, and the FSM state encodings RUN/HOLD/EXC/RET. These are shared with the CP0 and hazard units.
- One natural sub-module: f_npc_mux, the purely combinational priority selector producing npc and f_flush. The FSM, watchdog and counter stay in the top.

Test Plan:
- Reset released with all inputs 0, 3 edges → pc = 3000, 3004, 3008, 300C; state=RUN; f_adel=0.
- At pc=3010, br_taken=1, br_target=3400, d_is_branch=1 → f_bd=1 that cycle; next pc=3400.
- At pc=3400, stall=1 for 3 cycles, then req=1 with stall still 1:
  - stalled cycles: pc holds 3400.
  - after req edge: pc=4180, state=EXC, f_bd=0, exc_count=1.
- At pc=4200, eret=1 with epc=3014:
  - that cycle: f_flush=1.
  - next: pc=3014, state=RET.
  - following cycle: state=RUN.
- eret=1 with stall=1:
  - f_flush=0 and pc holds.
  - stall drops → redirect to epc.
- br_target=3402:
  - next cycle: f_adel=1.
- br_target=7000:
  - next cycle: f_adel=1.
- Watchdog and counter limits:
  - stall held 64 cycles → stall_timeout=1 and stays 1 after stall drops.
  - reset asserted mid-cycle → pc=3000 immediately.
  - 70000 req pulses → exc_count=FFFF.

Source files
------------

// File: rtl/f_fetch_seq_pkg.sv
// Fetch-stage constants and FSM encodings, shared with the CP0 and hazard units.
package f_fetch_seq_pkg;

  localparam logic [31:0] instr_start        = 32'h0000_3000;
  localparam logic [31:0] exception_entrance = 32'h0000_4180;
  localparam logic [31:0] im_lo              = 32'h0000_3000;
  localparam logic [31:0] im_hi              = 32'h0000_6FFF;
  localparam int unsigned wdog_max           = 64;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    EXC  = 2'd2,
    RET  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/f_fetch_seq_npc_mux.sv
// Next-PC priority selector: exception entrance, stall hold, ERET, branch target, PC+4.
module f_npc_mux
  import f_fetch_seq_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = exception_entrance
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] npc,
  output logic        f_flush
);

  // req beats stall; under stall the D-stage redirects are re-presented later
  always_comb begin
    npc = pc + 32'd4;
    if (req)
      npc = EXC_ENTRY;
    else if (stall)
      npc = pc;
    else if (eret)
      npc = epc;
    else if (br_taken)
      npc = br_target;
  end

  assign f_flush = eret & ~stall & ~req;

endmodule

// File: rtl/f_fetch_seq.sv
// Fetch-stage sequencer: owns the fetch PC, FSM, stall watchdog and exception counter.
module f_fetch_seq
  import f_fetch_seq_pkg::*;
#(
  parameter logic [31:0] START     = instr_start,
  parameter logic [31:0] EXC_ENTRY = exception_entrance,
  parameter logic [31:0] IM_LO     = im_lo,
  parameter logic [31:0] IM_HI     = im_hi,
  parameter int unsigned WDOG_MAX  = wdog_max
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        d_is_branch,
  output logic [31:0] pc,
  output logic        f_bd,
  output logic        f_adel,
  output logic        f_flush,
  output logic [1:0]  state,
  output logic        stall_timeout,
  output logic [15:0] exc_count
);

  localparam logic [6:0] wdog_lim = 7'(WDOG_MAX);

  fetch_state_t state_q;
  logic [31:0]  npc;
  logic [6:0]   hold_cnt;
  logic [6:0]   hold_next;

  f_npc_mux #(
    .EXC_ENTRY(EXC_ENTRY)
  ) u_npc_mux (
    .pc        (pc),
    .stall     (stall),
    .req       (req),
    .eret      (eret),
    .epc       (epc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .npc       (npc),
    .f_flush   (f_flush)
  );

  // Hold counter value after this edge; lets stall_timeout rise on the same edge the limit is hit
  always_comb begin
    hold_next = '0;
    if (stall && !req)
      hold_next = (hold_cnt == wdog_lim) ? hold_cnt : hold_cnt + 7'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= START;
      state_q       <= RUN;
      hold_cnt      <= '0;
      stall_timeout <= 1'b0;
      exc_count     <= '0;
    end else begin
      pc       <= npc;
      hold_cnt <= hold_next;
      if (hold_next == wdog_lim)
        stall_timeout <= 1'b1;
      if (req && exc_count != 16'hFFFF)
        exc_count <= exc_count + 16'd1;
      if (req)
        state_q <= EXC;
      else if (stall)
        state_q <= HOLD;
      else if (eret)
        state_q <= RET;
      else
        state_q <= RUN;
    end
  end

  assign state  = state_q;
  assign f_bd   = d_is_branch & (state_q != EXC);
  assign f_adel = (pc[1:0] != 2'b00) | (pc < IM_LO) | (pc > IM_HI);

endmodule

// File: tb/tb_f_fetch_seq.sv
// Directed bench for f_fetch_seq: redirect priority, FSM, address errors, watchdog, counter.
module tb_f_fetch_seq;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        d_is_branch;
  logic [31:0] pc;
  logic        f_bd;
  logic        f_adel;
  logic        f_flush;
  logic [1:0]  state;
  logic        stall_timeout;
  logic [15:0] exc_count;

  int checks;
  int failures;

  f_fetch_seq dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .req           (req),
    .eret          (eret),
    .epc           (epc),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .d_is_branch   (d_is_branch),
    .pc            (pc),
    .f_bd          (f_bd),
    .f_adel        (f_adel),
    .f_flush       (f_flush),
    .state         (state),
    .stall_timeout (stall_timeout),
    .exc_count     (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs changed afterwards affect only the next edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 0; req = 0; eret = 0; epc = '0;
    br_taken = 0; br_target = '0; d_is_branch = 0;
    #12;
    checks++; if (pc !== 32'h3000) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
    checks++; if (f_adel !== 1'b0) begin failures++; $display("[TB] FAIL reset_adel got=%b exp=0", f_adel); end
    checks++; if (stall_timeout !== 1'b0 || exc_count !== 16'h0) begin failures++; $display("[TB] FAIL reset_dbg got=%b/%h exp=0/0000", stall_timeout, exc_count); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc !== 32'h3000 + 32'(4 * i)) begin failures++; $display("[TB] FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'h3000 + 32'(4 * i)); end
    end
    checks++; if (state !== 2'd0 || f_adel !== 1'b0) begin failures++; $display("[TB] FAIL seq_state got=%0d/%b exp=0/0", state, f_adel); end
  endtask

  task automatic test_branch();
    br_taken = 1; br_target = 32'h3400; d_is_branch = 1;
    #1;
    checks++; if (f_bd !== 1'b1) begin failures++; $display("[TB] FAIL branch_bd got=%b exp=1", f_bd); end
    tick();
    br_taken = 0; d_is_branch = 0;
    checks++; if (pc !== 32'h3400) begin failures++; $display("[TB] FAIL branch_pc got=%h exp=%h", pc, 32'h3400); end
  endtask

  task automatic test_stall_req();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h3400 || state !== 2'd1) begin failures++; $display("[TB] FAIL stall_hold%0d got=%h/%0d exp=00003400/1", i, pc, state); end
    end
    req = 1;
    #1;
    checks++; if (f_flush !== 1'b0) begin failures++; $display("[TB] FAIL req_noflush got=%b exp=0", f_flush); end
    tick();
    req = 0; stall = 0; d_is_branch = 1;
    #1;
    checks++; if (pc !== 32'h4180 || state !== 2'd2) begin failures++; $display("[TB] FAIL req_entry got=%h/%0d exp=00004180/2", pc, state); end
    checks++; if (f_bd !== 1'b0) begin failures++; $display("[TB] FAIL exc_bd got=%b exp=0", f_bd); end
    checks++; if (exc_count !== 16'd1) begin failures++; $display("[TB] FAIL exc_count1 got=%h exp=0001", exc_count); end
    br_taken = 1; br_target = 32'h4200;
    tick();
    br_taken = 0;
    #1;
    checks++; if (pc !== 32'h4200 || state !== 2'd0 || f_bd !== 1'b1) begin failures++; $display("[TB] FAIL exc_exit got=%h/%0d/%b exp=00004200/0/1", pc, state, f_bd); end
    d_is_branch = 0;
  endtask

  task automatic test_eret();
    eret = 1; epc = 32'h3014;
    #1;
    checks++; if (f_flush !== 1'b1) begin failures++; $display("[TB] FAIL eret_flush got=%b exp=1", f_flush); end
    tick();
    eret = 0;
    checks++; if (pc !== 32'h3014 || state !== 2'd3) begin failures++; $display("[TB] FAIL eret_ret got=%h/%0d exp=00003014/3", pc, state); end
    tick();
    checks++; if (pc !== 32'h3018 || state !== 2'd0) begin failures++; $display("[TB] FAIL eret_run got=%h/%0d exp=00003018/0", pc, state); end
  endtask

  task automatic test_eret_stall();
    eret = 1; stall = 1; epc = 32'h3100;
    #1;
    checks++; if (f_flush !== 1'b0) begin failures++; $display("[TB] FAIL eretst_flush got=%b exp=0", f_flush); end
    tick();
    checks++; if (pc !== 32'h3018 || state !== 2'd1) begin failures++; $display("[TB] FAIL eretst_hold got=%h/%0d exp=00003018/1", pc, state); end
    stall = 0;
    #1;
    checks++; if (f_flush !== 1'b1) begin failures++; $display("[TB] FAIL eretst_flush2 got=%b exp=1", f_flush); end
    tick();
    checks++; if (pc !== 32'h3100 || state !== 2'd3) begin failures++; $display("[TB] FAIL eretst_redir got=%h/%0d exp=00003100/3", pc, state); end
    epc = 32'h3200; br_taken = 1; br_target = 32'h3300;
    tick();
    eret = 0; br_taken = 0;
    checks++; if (pc !== 32'h3200) begin failures++; $display("[TB] FAIL eret_over_br got=%h exp=00003200", pc); end
  endtask

  task automatic test_adel();
    logic [31:0] tgt [6];
    logic        exp_adel [6];
    tgt = '{32'h3402, 32'h7000, 32'h6FFC, 32'h2FFC, 32'hFFFF_FFFC, 32'h3000};
    exp_adel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    #1;
    checks++; if (f_adel !== 1'b0) begin failures++; $display("[TB] FAIL adel_pre got=%b exp=0", f_adel); end
    for (int i = 0; i < 6; i++) begin
      br_taken = 1; br_target = tgt[i];
      tick();
      br_taken = 0;
      checks++; if (pc !== tgt[i] || f_adel !== exp_adel[i]) begin failures++; $display("[TB] FAIL adel_%0d got=%h/%b exp=%h/%b", i, pc, f_adel, tgt[i], exp_adel[i]); end
      if (i == 4) begin
        tick();
        checks++; if (pc !== 32'h0 || f_adel !== 1'b1) begin failures++; $display("[TB] FAIL pc_wrap got=%h/%b exp=00000000/1", pc, f_adel); end
      end
    end
  endtask

  task automatic test_watchdog();
    stall = 1;
    for (int i = 0; i < 63; i++) tick();
    checks++; if (stall_timeout !== 1'b0 || pc !== 32'h3000) begin failures++; $display("[TB] FAIL wdog_63 got=%b/%h exp=0/00003000", stall_timeout, pc); end
    tick();
    checks++; if (stall_timeout !== 1'b1) begin failures++; $display("[TB] FAIL wdog_64 got=%b exp=1", stall_timeout); end
    stall = 0;
    tick();
    checks++; if (stall_timeout !== 1'b1 || state !== 2'd0) begin failures++; $display("[TB] FAIL wdog_sticky got=%b/%0d exp=1/0", stall_timeout, state); end
  endtask

  task automatic test_reset_mid();
    stall = 1; br_taken = 1; br_target = 32'h5000;
    tick();
    #2;
    reset = 1;
    #1;
    checks++; if (pc !== 32'h3000 || state !== 2'd0) begin failures++; $display("[TB] FAIL rstmid_pc got=%h/%0d exp=00003000/0", pc, state); end
    checks++; if (stall_timeout !== 1'b0 || exc_count !== 16'h0) begin failures++; $display("[TB] FAIL rstmid_dbg got=%b/%h exp=0/0000", stall_timeout, exc_count); end
    stall = 0; br_taken = 0;
    @(negedge clk);
    reset = 0;
    tick();
    checks++; if (pc !== 32'h3004) begin failures++; $display("[TB] FAIL rstmid_resume got=%h exp=00003004", pc); end
  endtask

  task automatic test_exc_saturate();
    req = 1; eret = 1; epc = 32'h3100;
    #1;
    checks++; if (f_flush !== 1'b0) begin failures++; $display("[TB] FAIL req_eret_flush got=%b exp=0", f_flush); end
    eret = 0;
    repeat (65534) tick();
    checks++; if (exc_count !== 16'hFFFE) begin failures++; $display("[TB] FAIL exc_fffe got=%h exp=fffe", exc_count); end
    tick();
    checks++; if (exc_count !== 16'hFFFF) begin failures++; $display("[TB] FAIL exc_ffff got=%h exp=ffff", exc_count); end
    repeat (70000 - 65535) tick();
    checks++; if (exc_count !== 16'hFFFF || pc !== 32'h4180 || state !== 2'd2) begin failures++; $display("[TB] FAIL exc_sat got=%h/%h/%0d exp=ffff/00004180/2", exc_count, pc, state); end
    req = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_req();
    test_eret();
    test_eret_stall();
    test_adel();
    test_watchdog();
    test_reset_mid();
    test_exc_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
